// File: rtl/dcache_direct_wt_if.sv
// Core/memory bus bundle seen by the direct-mapped write-through data cache.
// Latency: none (wires only).
// Backpressure: memory request is valid/ready; refill response is a single unconditional beat.
interface dcache_direct_wt_if;
    logic [31:0]  cpu_addr;
    logic         cpu_re;
    logic [3:0]   cpu_we;
    logic [31:0]  cpu_din;
    logic [31:0]  cpu_dout;
    logic         stall;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic         mem_req_rw;
    logic [27:0]  mem_req_addr;
    logic [127:0] mem_req_data;
    logic [15:0]  mem_req_mask;
    logic         mem_resp_valid;
    logic [127:0] mem_resp_data;

    // Cache side: serves the core, drives the memory request.
    modport slave (
        input  cpu_addr, cpu_re, cpu_we, cpu_din,
        output cpu_dout, stall,
        output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data, mem_req_mask,
        input  mem_req_ready, mem_resp_valid, mem_resp_data
    );

    // Environment side: core plus memory.
    modport master (
        output cpu_addr, cpu_re, cpu_we, cpu_din,
        input  cpu_dout, stall,
        input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data, mem_req_mask,
        output mem_req_ready, mem_resp_valid, mem_resp_data
    );
endinterface

// File: rtl/dcache_direct_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache with 128-bit lines.
// Latency: load hit returns data in the cycle after capture; misses and stores stall.
// Backpressure: stall holds the core; one memory request in flight, held stable until ready.
module dcache_direct_wt #(
    parameter int LINES = 64
) (
    input  logic            clk,
    input  logic            reset,
    dcache_direct_wt_if.slave bus
);
    localparam int IDX   = $clog2(LINES);
    localparam int TAG_W = 28 - IDX;

    typedef enum logic [2:0] {
        IDLE, LOOKUP, WRITE, REFILL_REQ, REFILL_WAIT, DONE
    } state_t;

    state_t             state;
    logic [LINES-1:0]   valid_q;
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [127:0]       data_q [LINES];

    logic [31:2]        req_addr;
    logic [3:0]         req_we;
    logic [31:0]        req_din;
    logic               req_hit;
    logic [31:0]        dout_q;

    logic               mem_req_valid_q;
    logic               mem_req_rw_q;
    logic [27:0]        mem_req_addr_q;
    logic [127:0]       mem_req_data_q;
    logic [15:0]        mem_req_mask_q;

    logic [IDX-1:0]     req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic [1:0]         req_word;
    logic               hit;
    logic               is_store;
    logic               load_hit;
    logic [127:0]       line_rd;
    logic [31:0]        word_rd;
    logic               stall_c;
    logic               capture;
    logic               refill_we;
    logic               merge_we;
    logic [127:0]       merged_line;
    logic               unused_addr_bits;

    assign req_idx  = req_addr[IDX+3:4];
    assign req_tag  = req_addr[31:IDX+4];
    assign req_word = req_addr[3:2];
    assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign is_store = (req_we != 4'h0);
    assign load_hit = (state == LOOKUP) && hit && !is_store;
    assign line_rd  = data_q[req_idx];
    assign word_rd  = line_rd[{req_word, 5'b0} +: 32];

    // Byte offset within a word carries no information for a word-wide port.
    assign unused_addr_bits = ^bus.cpu_addr[1:0];

    // Stall whenever the core must wait on the cache or the memory.
    always_comb begin
        stall_c = 1'b0;
        case (state)
            LOOKUP:                         stall_c = !load_hit;
            WRITE, REFILL_REQ, REFILL_WAIT: stall_c = 1'b1;
            default:                        stall_c = 1'b0;
        endcase
    end

    assign capture   = !stall_c && (bus.cpu_re || (bus.cpu_we != 4'h0));
    assign refill_we = (state == REFILL_WAIT) && bus.mem_resp_valid;
    assign merge_we  = (state == WRITE) && bus.mem_req_ready && req_hit;

    // Store hit: fold the enabled bytes of the outgoing write into the cached line.
    always_comb begin
        merged_line = line_rd;
        for (int b = 0; b < 16; b++) begin
            if (mem_req_mask_q[b]) begin
                merged_line[8*b +: 8] = mem_req_data_q[8*b +: 8];
            end
        end
    end

    // Line storage: refill replaces the whole line, a store hit merges bytes.
    always_ff @(posedge clk) begin
        if (refill_we) begin
            data_q[req_idx] <= bus.mem_resp_data;
            tag_q[req_idx]  <= req_tag;
        end else if (merge_we) begin
            data_q[req_idx] <= merged_line;
        end
    end

    // Control FSM with registered memory request fields and held load data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            valid_q         <= '0;
            req_addr        <= '0;
            req_we          <= '0;
            req_din         <= '0;
            req_hit         <= 1'b0;
            dout_q          <= '0;
            mem_req_valid_q <= 1'b0;
            mem_req_rw_q    <= 1'b0;
            mem_req_addr_q  <= '0;
            mem_req_data_q  <= '0;
            mem_req_mask_q  <= '0;
        end else begin
            if (capture) begin
                req_addr <= bus.cpu_addr[31:2];
                req_we   <= bus.cpu_we;
                req_din  <= bus.cpu_din;
            end
            case (state)
                IDLE: begin
                    state <= capture ? LOOKUP : IDLE;
                end
                LOOKUP: begin
                    if (is_store) begin
                        mem_req_valid_q <= 1'b1;
                        mem_req_rw_q    <= 1'b1;
                        mem_req_addr_q  <= req_addr[31:4];
                        mem_req_data_q  <= {4{req_din}};
                        mem_req_mask_q  <= {12'b0, req_we} << {req_word, 2'b00};
                        req_hit         <= hit;
                        state           <= WRITE;
                    end else if (hit) begin
                        dout_q <= word_rd;
                        state  <= capture ? LOOKUP : IDLE;
                    end else begin
                        mem_req_valid_q <= 1'b1;
                        mem_req_rw_q    <= 1'b0;
                        mem_req_addr_q  <= req_addr[31:4];
                        mem_req_data_q  <= '0;
                        mem_req_mask_q  <= '0;
                        state           <= REFILL_REQ;
                    end
                end
                WRITE: begin
                    if (bus.mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        state           <= IDLE;
                    end
                end
                REFILL_REQ: begin
                    if (bus.mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        state           <= REFILL_WAIT;
                    end
                end
                REFILL_WAIT: begin
                    if (bus.mem_resp_valid) begin
                        valid_q[req_idx] <= 1'b1;
                        state            <= DONE;
                    end
                end
                DONE: begin
                    dout_q <= word_rd;
                    state  <= capture ? LOOKUP : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.stall         = stall_c;
    assign bus.cpu_dout      = (load_hit || (state == DONE)) ? word_rd : dout_q;
    assign bus.mem_req_valid = mem_req_valid_q;
    assign bus.mem_req_rw    = mem_req_rw_q;
    assign bus.mem_req_addr  = mem_req_addr_q;
    assign bus.mem_req_data  = mem_req_data_q;
    assign bus.mem_req_mask  = mem_req_mask_q;
endmodule

// File: tb/tb_dcache_direct_wt.sv
module tb_dcache_direct_wt;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dcache_direct_wt_if ifc();
    dcache_direct_wt #(.LINES(64)) dut (.clk(clk), .reset(reset), .bus(ifc));

    typedef struct packed {
        logic         rw;
        logic [27:0]  addr;
        logic [127:0] data;
        logic [15:0]  mask;
    } memreq_t;

    typedef struct {
        logic [31:0] addr;
        logic        re;
        logic [3:0]  we;
        logic [31:0] din;
        int          hold;
        int          exp_rd;
        logic [31:0] exp_dout;
        logic [15:0] exp_mask;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // environment (memory) state, owned by the responder process
    memreq_t      mem_log[$];
    logic [127:0] env_mem [logic [27:0]];
    logic         auto_resp_vld = 1'b0;
    logic [127:0] auto_resp_dat = '0;
    // main-process controls
    logic         man_resp_vld = 1'b0;
    logic [127:0] man_resp_dat = '0;
    int           ready_hold_set = 0;
    bit           ready_random = 1'b0;
    bit           auto_resp_en = 1'b1;

    // reference model state
    logic [127:0] ref_mem [logic [27:0]];
    bit           mvalid [64];
    logic [21:0]  mtag [64];

    assign ifc.mem_resp_valid = auto_resp_vld | man_resp_vld;
    assign ifc.mem_resp_data  = man_resp_vld ? man_resp_dat : auto_resp_dat;

    // initial contents of the backing memory
    function automatic logic [127:0] init_line(input logic [27:0] la);
        if (la == 28'h000_0100) return 128'h44444444_33333333_22222222_11111111;
        if (la == 28'h000_0140) return 128'h04040003_04040002_04040001_04040000;
        return {~{4'h3, la}, {4'h2, la}, ~{4'h1, la}, {4'h0, la}};
    endfunction

    function automatic logic [127:0] env_get(input logic [27:0] la);
        return env_mem.exists(la) ? env_mem[la] : init_line(la);
    endfunction

    function automatic logic [127:0] ref_get(input logic [27:0] la);
        return ref_mem.exists(la) ? ref_mem[la] : init_line(la);
    endfunction

    function automatic void check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic void check_i(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endfunction

    // Reference: memory is the truth; cache only decides hit/miss by a valid/tag table.
    function automatic void model_predict(input logic [31:0] addr, input logic [3:0] we,
                                          input logic [31:0] din, output logic [31:0] dout,
                                          output bit miss, output logic [15:0] mask);
        logic [27:0]  la;
        int           idx;
        int           w;
        logic [127:0] line;
        la   = addr[31:4];
        idx  = int'(addr[9:4]);
        w    = int'(addr[3:2]);
        line = ref_get(la);
        mask = '0;
        dout = '0;
        miss = 1'b0;
        if (we != 4'h0) begin
            for (int b = 0; b < 4; b++) begin
                if (we[b]) begin
                    mask[4*w + b] = 1'b1;
                    line[32*w + 8*b +: 8] = din[8*b +: 8];
                end
            end
            ref_mem[la] = line;
        end else begin
            miss = !(mvalid[idx] && mtag[idx] == addr[31:10]);
            if (miss) begin
                mvalid[idx] = 1'b1;
                mtag[idx]   = addr[31:10];
            end
            dout = line[32*w +: 32];
        end
    endfunction

    // Memory responder: random ready, applies writes, returns refills after a random delay.
    initial begin : mem_responder
        int           hold_cnt;
        int           resp_cnt;
        bit           pending;
        memreq_t      cur;
        logic [27:0]  resp_la;
        logic [127:0] ln;
        hold_cnt = 0;
        resp_cnt = 0;
        pending  = 1'b0;
        resp_la  = '0;
        ifc.mem_req_ready = 1'b0;
        forever begin
            @(negedge clk);
            auto_resp_vld = 1'b0;
            if (!reset) begin
                ifc.mem_req_ready = 1'b0;
                resp_cnt = 0;
                pending  = 1'b0;
            end else begin
                if (resp_cnt > 0) begin
                    resp_cnt--;
                    if (resp_cnt == 0) begin
                        auto_resp_vld = 1'b1;
                        auto_resp_dat = env_get(resp_la);
                    end
                end
                if (ifc.mem_req_valid) begin
                    cur.rw   = ifc.mem_req_rw;
                    cur.addr = ifc.mem_req_addr;
                    cur.data = ifc.mem_req_data;
                    cur.mask = ifc.mem_req_mask;
                    if (!pending) hold_cnt = ready_hold_set;
                    if (hold_cnt > 0 || (ready_random && $urandom_range(0, 2) == 0)) begin
                        if (hold_cnt > 0) hold_cnt--;
                        ifc.mem_req_ready = 1'b0;
                        pending = 1'b1;
                    end else begin
                        ifc.mem_req_ready = 1'b1;
                        pending = 1'b0;
                        mem_log.push_back(cur);
                        if (cur.rw) begin
                            ln = env_get(cur.addr);
                            for (int b = 0; b < 16; b++)
                                if (cur.mask[b]) ln[8*b +: 8] = cur.data[8*b +: 8];
                            env_mem[cur.addr] = ln;
                        end else if (auto_resp_en) begin
                            resp_cnt = 1 + int'($urandom_range(0, 3));
                            resp_la  = cur.addr;
                        end
                    end
                end else begin
                    ifc.mem_req_ready = 1'b0;
                    pending = 1'b0;
                end
            end
        end
    end

    // One core access: present at a negedge, wait for stall to drop, collect memory traffic.
    task automatic run_access(input logic [31:0] addr, input logic re, input logic [3:0] we,
                              input logic [31:0] din, input int hold,
                              output logic [31:0] dout, output int stalls,
                              output int nrd, output int nwr, output memreq_t last);
        int      base;
        bit      done;
        bit      prev_pend;
        memreq_t cur;
        memreq_t prev;
        @(negedge clk);
        ready_hold_set = hold;
        base = mem_log.size();
        ifc.cpu_addr = addr;
        ifc.cpu_re   = re;
        ifc.cpu_we   = we;
        ifc.cpu_din  = din;
        @(posedge clk);
        stalls = 0;
        done = 1'b0;
        prev_pend = 1'b0;
        prev = '0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            #1;
            cur.rw   = ifc.mem_req_rw;
            cur.addr = ifc.mem_req_addr;
            cur.data = ifc.mem_req_data;
            cur.mask = ifc.mem_req_mask;
            if (prev_pend && ifc.mem_req_valid) check("req_stable", cur, prev);
            prev_pend = ifc.mem_req_valid && !ifc.mem_req_ready;
            prev = cur;
            if (ifc.stall) stalls++;
            else done = 1'b1;
        end
        dout = ifc.cpu_dout;
        ifc.cpu_re = 1'b0;
        ifc.cpu_we = 4'h0;
        ready_hold_set = 0;
        if (!done) check_i("access_timeout", 0, 1);
        nrd = 0;
        nwr = 0;
        last = '0;
        for (int i = base; i < mem_log.size(); i++) begin
            if (mem_log[i].rw) nwr++;
            else nrd++;
            last = mem_log[i];
        end
    endtask

    // Access checked against the reference model.
    task automatic do_op(input string nm, input logic [31:0] addr, input logic re,
                         input logic [3:0] we, input logic [31:0] din, input int hold,
                         output logic [31:0] o_dout, output int o_nrd, output logic [15:0] o_mask);
        logic [31:0] m_dout;
        bit          m_miss;
        logic [15:0] m_mask;
        int          stalls;
        int          nwr;
        memreq_t     last;
        model_predict(addr, we, din, m_dout, m_miss, m_mask);
        run_access(addr, re, we, din, hold, o_dout, stalls, o_nrd, nwr, last);
        o_mask = last.mask;
        if (we != 4'h0) begin
            check_i({nm, " wr_cnt"}, nwr, 1);
            check_i({nm, " rd_cnt"}, o_nrd, 0);
            check({nm, " wr_mask"}, 128'(last.mask), 128'(m_mask));
            check({nm, " wr_data"}, last.data, {4{din}});
            check({nm, " wr_addr"}, 128'(last.addr), 128'(addr[31:4]));
            check_i({nm, " st_stall>=2"}, int'(stalls >= 2), 1);
        end else begin
            check({nm, " dout"}, 128'(o_dout), 128'(m_dout));
            check_i({nm, " rd_cnt"}, o_nrd, int'(m_miss));
            check_i({nm, " wr_cnt"}, nwr, 0);
            if (m_miss) begin
                check({nm, " rd_addr"}, 128'(last.addr), 128'(addr[31:4]));
                check_i({nm, " miss_stall>=3"}, int'(stalls >= 3), 1);
            end else begin
                check_i({nm, " hit_stall"}, stalls, 0);
            end
        end
    endtask

    vec_t tbl[11];

    initial begin : main
        logic [31:0] dout;
        int          nrd;
        logic [15:0] mask;
        int          base;
        bit          got;

        tbl[0]  = '{32'h0000_1004, 1'b1, 4'h0, 32'h0,         0, 1, 32'h22222222, 16'h0000};
        tbl[1]  = '{32'h0000_100C, 1'b1, 4'h0, 32'h0,         0, 0, 32'h44444444, 16'h0000};
        tbl[2]  = '{32'h0000_1008, 1'b0, 4'h3, 32'hAAAA_BBBB, 3, 0, 32'h0,        16'h0300};
        tbl[3]  = '{32'h0000_1008, 1'b1, 4'h0, 32'h0,         0, 0, 32'h3333BBBB, 16'h0000};
        tbl[4]  = '{32'h0002_0000, 1'b0, 4'hF, 32'h1234_5678, 0, 0, 32'h0,        16'h000F};
        tbl[5]  = '{32'h0002_0000, 1'b1, 4'h0, 32'h0,         0, 1, 32'h12345678, 16'h0000};
        tbl[6]  = '{32'h0000_1404, 1'b1, 4'h0, 32'h0,         0, 1, 32'h04040001, 16'h0000};
        tbl[7]  = '{32'h0000_1004, 1'b1, 4'h0, 32'h0,         0, 1, 32'h22222222, 16'h0000};
        tbl[8]  = '{32'h0000_1000, 1'b1, 4'h8, 32'hCC00_0000, 0, 0, 32'h0,        16'h0008};
        tbl[9]  = '{32'h0000_1000, 1'b1, 4'h0, 32'h0,         0, 0, 32'hCC111111, 16'h0000};
        tbl[10] = '{32'h0000_100C, 1'b1, 4'h0, 32'h0,         0, 0, 32'h44444444, 16'h0000};

        ifc.cpu_addr = '0;
        ifc.cpu_re   = 1'b0;
        ifc.cpu_we   = 4'h0;
        ifc.cpu_din  = '0;
        for (int i = 0; i < 64; i++) begin
            mvalid[i] = 1'b0;
            mtag[i]   = '0;
        end

        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst stall", 128'(ifc.stall), 128'(0));
        check("rst mem_req_valid", 128'(ifc.mem_req_valid), 128'(0));
        check("rst cpu_dout", 128'(ifc.cpu_dout), 128'(0));
        reset = 1'b1;
        @(negedge clk);

        // directed vectors
        for (int i = 0; i < 11; i++) begin
            do_op($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].re, tbl[i].we, tbl[i].din,
                  tbl[i].hold, dout, nrd, mask);
            check_i($sformatf("tbl%0d exp_rd", i), nrd, tbl[i].exp_rd);
            if (tbl[i].we == 4'h0) check($sformatf("tbl%0d exp_dout", i), 128'(dout), 128'(tbl[i].exp_dout));
            else check($sformatf("tbl%0d exp_mask", i), 128'(mask), 128'(tbl[i].exp_mask));
        end

        // reset while a refill is outstanding; late response must be ignored
        auto_resp_en = 1'b0;
        @(negedge clk);
        base = mem_log.size();
        ifc.cpu_addr = 32'h0000_3004;
        ifc.cpu_re   = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            #1;
            if (mem_log.size() > base) got = 1'b1;
        end
        check_i("rstw refill_req_seen", int'(got), 1);
        @(negedge clk);
        #1;
        check("rstw stall_in_wait", 128'(ifc.stall), 128'(1));
        check("rstw req_dropped", 128'(ifc.mem_req_valid), 128'(0));
        reset = 1'b0;
        ifc.cpu_re = 1'b0;
        #1;
        check("rstw stall", 128'(ifc.stall), 128'(0));
        check("rstw mem_req_valid", 128'(ifc.mem_req_valid), 128'(0));
        check("rstw cpu_dout", 128'(ifc.cpu_dout), 128'(0));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        man_resp_dat = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
        man_resp_vld = 1'b1;
        @(negedge clk);
        man_resp_vld = 1'b0;
        #1;
        check("rstw late_resp stall", 128'(ifc.stall), 128'(0));
        check("rstw late_resp req", 128'(ifc.mem_req_valid), 128'(0));
        for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
        auto_resp_en = 1'b1;
        do_op("rstw reload1004", 32'h0000_1004, 1'b1, 4'h0, 32'h0, 0, dout, nrd, mask);
        check_i("rstw reload1004 miss", nrd, 1);
        do_op("rstw reload3004", 32'h0000_3004, 1'b1, 4'h0, 32'h0, 0, dout, nrd, mask);
        check_i("rstw reload3004 miss", nrd, 1);

        // randomized traffic over a small set of conflicting lines
        ready_random = 1'b1;
        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            logic [31:0] idxv;
            logic [3:0]  we;
            logic        re;
            case ($urandom_range(0, 3))
                0: idxv = 32'd0;
                1: idxv = 32'd1;
                2: idxv = 32'd2;
                default: idxv = 32'd63;
            endcase
            a = (32'($urandom_range(0, 3)) << 10) | (idxv << 4) | 32'($urandom_range(0, 15));
            if ($urandom_range(0, 9) < 5) begin
                we = 4'h0;
                re = 1'b1;
            end else begin
                we = 4'($urandom_range(1, 15));
                re = 1'($urandom_range(0, 1));
            end
            do_op($sformatf("rnd%0d", n), a, re, we, $urandom, int'($urandom_range(0, 2)),
                  dout, nrd, mask);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
